// File: rtl/hv_encode_seq.sv
// Encode sequencer: accumulates item-bind results, optionally adds a tie-break
// update for even item counts, latches the sign vector and streams it out.
module hv_encode_seq #(
  parameter int CNT_W     = 8,
  parameter int NUM_WORDS = 1,
  parameter int ADDR_W    = 8,
  parameter int SIGN_LAT  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_items,
  input  logic              item_valid,
  output logic              item_ready,
  output logic              update,
  output logic              last_update,
  output logic              tmp_addr_i,
  output logic              get_fin,
  output logic              stream_v,
  output logic [ADDR_W-1:0] stream_a,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    TIEBRK = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4,
    RDREQ  = 3'd5,
    OUT    = 3'd6,
    FIN    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);
  localparam logic [7:0]        SETTLE_LD = 8'(SIGN_LAT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  rem_q;
  logic              even_q;
  logic [7:0]        settle_q;
  logic [ADDR_W-1:0] word_q;
  logic              item_ready_q;
  logic              tiebrk_q;
  logic              get_fin_q;
  logic              stream_v_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic              busy_q;
  logic              done_q;

  logic              accept_s;
  logic              final_item_s;

  // Item updates are the only combinational path: they follow item_valid in the same cycle.
  assign accept_s     = (state_q == ACCUM) & item_valid;
  assign final_item_s = accept_s & (rem_q == CNT_W'(1));

  assign update      = accept_s | tiebrk_q;
  assign last_update = (final_item_s & ~even_q) | tiebrk_q;
  assign tmp_addr_i  = tiebrk_q;
  assign item_ready  = item_ready_q;
  assign get_fin     = get_fin_q;
  assign stream_v    = stream_v_q;
  assign stream_a    = word_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      even_q       <= 1'b0;
      settle_q     <= 8'd0;
      word_q       <= '0;
      item_ready_q <= 1'b0;
      tiebrk_q     <= 1'b0;
      get_fin_q    <= 1'b0;
      stream_v_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      tiebrk_q   <= 1'b0;
      get_fin_q  <= 1'b0;
      stream_v_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && (num_items != '0)) begin
            state_q      <= ACCUM;
            rem_q        <= num_items;
            even_q       <= ~num_items[0];
            item_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            rem_q <= rem_q - CNT_W'(1);
            if (final_item_s) begin
              item_ready_q <= 1'b0;
              settle_q     <= SETTLE_LD;
              if (even_q) begin
                state_q  <= TIEBRK;
                tiebrk_q <= 1'b1;
              end else begin
                state_q <= SETTLE;
              end
            end
          end
        end
        TIEBRK: begin
          state_q  <= SETTLE;
          settle_q <= SETTLE_LD;
        end
        // Sign bits need SIGN_LAT cycles after the last counter update.
        SETTLE: begin
          if (settle_q == 8'd0) begin
            state_q   <= LATCH;
            get_fin_q <= 1'b1;
          end else begin
            settle_q <= settle_q - 8'd1;
          end
        end
        LATCH: begin
          state_q    <= RDREQ;
          word_q     <= '0;
          stream_v_q <= 1'b1;
        end
        RDREQ: begin
          state_q   <= OUT;
          m_valid_q <= 1'b1;
          m_last_q  <= (word_q == LAST_WORD);
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            if (m_last_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= RDREQ;
              word_q     <= word_q + ADDR_W'(1);
              stream_v_q <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          word_q  <= '0;
        end
        default: begin
          state_q      <= IDLE;
          item_ready_q <= 1'b0;
          m_valid_q    <= 1'b0;
          m_last_q     <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_encode_seq.sv
// Self-checking bench for hv_encode_seq: directed encodes with a scoreboard of
// expected updates, stream addresses and last flags.
module tb_hv_encode_seq;

  localparam int NW = 4;
  localparam int SL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_items;
  logic       item_valid;
  logic       item_ready;
  logic       update;
  logic       last_update;
  logic       tmp_addr_i;
  logic       get_fin;
  logic       stream_v;
  logic [7:0] stream_a;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  hv_encode_seq #(.CNT_W(8), .NUM_WORDS(NW), .ADDR_W(8), .SIGN_LAT(SL)) dut (
    .clk(clk), .rst(rst), .start(start), .num_items(num_items),
    .item_valid(item_valid), .item_ready(item_ready), .update(update),
    .last_update(last_update), .tmp_addr_i(tmp_addr_i), .get_fin(get_fin),
    .stream_v(stream_v), .stream_a(stream_a), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic tmp;
    logic last;
  } upd_t;

  upd_t       upd_q[$];
  logic [7:0] addr_q[$];
  logic       last_q[$];
  upd_t       e_upd;
  logic [7:0] e_addr;
  logic       e_last;

  int   n_checks = 0;
  int   n_fail = 0;
  int   done_exp = 0;
  int   done_seen = 0;
  int   since_lu = 0;
  logic lu_armed = 1'b0;
  logic prev_stall = 1'b0;
  logic prev_mlast = 1'b0;
  logic prev_final_hs = 1'b0;

  wire [17:0] outs_vec = {item_ready, update, last_update, tmp_addr_i, get_fin,
                          stream_v, stream_a, m_valid, m_last, busy, done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int n);
    for (int i = 0; i < n; i++) upd_q.push_back({1'b0, (i == n - 1) && (n % 2 == 1)});
    if (n % 2 == 0) upd_q.push_back({1'b1, 1'b1});
    for (int w = 0; w < NW; w++) begin
      addr_q.push_back(8'(w));
      last_q.push_back(w == NW - 1);
    end
  endtask

  // Monitor: pops expectations as the DUT produces updates, reads and words.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall    = 1'b0;
      prev_final_hs = 1'b0;
      lu_armed      = 1'b0;
      since_lu      = 0;
    end else begin
      if (update) begin
        if (upd_q.size() == 0) chk("upd_extra", 32'd1, 32'd0);
        else begin
          e_upd = upd_q.pop_front();
          chk("upd_tmp", 32'(tmp_addr_i), 32'(e_upd.tmp));
          chk("upd_last", 32'(last_update), 32'(e_upd.last));
        end
        if (!tmp_addr_i) chk("upd_needs_valid", 32'(item_valid), 32'd1);
      end else begin
        chk("flags_wo_upd", 32'({tmp_addr_i, last_update}), 32'd0);
      end
      if (tmp_addr_i | get_fin | stream_v) begin
        chk("excl_ready", 32'(item_ready), 32'd0);
        chk("excl_onehot", 32'($countones({tmp_addr_i, get_fin, stream_v})), 32'd1);
      end
      if (lu_armed) since_lu++;
      if (get_fin) begin
        chk("getfin_lat", lu_armed ? 32'(since_lu) : 32'hffff, 32'(SL + 1));
        lu_armed = 1'b0;
      end
      if (last_update) begin
        lu_armed = 1'b1;
        since_lu = 0;
      end
      if (stream_v) begin
        if (addr_q.size() == 0) chk("rd_extra", 32'd1, 32'd0);
        else begin
          e_addr = addr_q.pop_front();
          chk("stream_a", 32'(stream_a), 32'(e_addr));
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_last", 32'(m_last), 32'(prev_mlast));
      end
      if (m_valid && m_ready) begin
        if (last_q.size() == 0) chk("word_extra", 32'd1, 32'd0);
        else begin
          e_last = last_q.pop_front();
          chk("m_last", 32'(m_last), 32'(e_last));
        end
      end
      if (prev_final_hs || done) chk("done_timing", 32'(done), 32'(prev_final_hs));
      if (done) done_seen++;
      prev_stall    = m_valid & ~m_ready;
      prev_mlast    = m_last;
      prev_final_hs = m_valid & m_ready & m_last;
    end
  end

  task automatic run_encode(input int n, input int gap, input bit toggle, input bit busy_start);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; num_items = 8'(n); item_valid = 1'b0; m_ready = 1'b0;
    push_exp(n);
    done_exp++;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      item_valid = (gap == 0) ? 1'b1 : ((c % (gap + 1)) == gap);
      m_ready    = toggle ? c[0] : 1'b1;
      if (busy_start && c == 3) begin
        start = 1'b1; num_items = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("encode_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    item_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b0; start = 1'b0; num_items = 8'd0; item_valid = 1'b0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(outs_vec), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_encode(3, 0, 1'b0, 1'b0);
    run_encode(4, 0, 1'b0, 1'b1);
    run_encode(1, 5, 1'b0, 1'b0);
    run_encode(6, 1, 1'b1, 1'b0);

    // Zero-item start must be ignored entirely.
    @(posedge clk); #1;
    start = 1'b1; num_items = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zero_start_busy", 32'(busy), 32'd0);
    end

    // Abort with reset while a word is being offered.
    @(posedge clk); #1;
    start = 1'b1; num_items = 8'd2; item_valid = 1'b1; m_ready = 1'b0;
    push_exp(2);
    @(posedge clk); #1;
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    chk("reach_out", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    upd_q.delete(); addr_q.delete(); last_q.delete();
    @(negedge clk);
    chk("abort_outs", 32'(outs_vec), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; item_valid = 1'b0;
    @(negedge clk);
    chk("post_abort_outs", 32'(outs_vec), 32'd0);
    run_encode(3, 0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    chk("queues_empty", 32'(upd_q.size() + addr_q.size() + last_q.size()), 32'd0);
    chk("done_count", 32'(done_seen), 32'(done_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
